mul_tree_result_collector: RTL and testbench
============================================

# mul_tree_result_collector

Receive-side companion to `mul_tree_bf16`. It captures the four result lanes (`outputs`, `final_output_stbs_1`) whenever lane strobes fire, and filters them by the active tree `mode`. Accepted results are queued in lane order in an internal FIFO and drained one result per beat over a stb/ack handshake, toward a serializer, memory writer or bench scoreboard. The block replaces the file-dump capture used in simulation and makes the tree usable against a downstream consumer that stalls.

## Interface
- `DW`, 16 — result width per lane (bf16).
- `DEPTH`, 16 — FIFO entries; power of two, minimum 4.
- `clk` in 1 — single clock; all logic rising-edge.
- `rst` in 1 — synchronous, active-high reset.
- `mode` in 2 — tree mode, same encoding as `mul_tree_bf16`; sampled every cycle.
- `tree_outputs` in 4*DW — lane k occupies bits [k*DW +: DW].
- `tree_stbs` in 4 — per-lane result valid, one-cycle pulses.
- `res_data` out DW — head-of-FIFO result.
- `res_lane` out 2 — lane index the head result came from.
- `res_stb` out 1 — head valid.
- `res_ack` in 1 — consumer accepts head when `res_stb && res_ack`.
- `res_count` out 16 — accepted results since reset; wraps 0xFFFF→0.
- `overflow` out 1 — sticky: a strobe group was dropped.
- `level` out $clog2(DEPTH)+1 — current FIFO occupancy.

## Operation
- Lane enable mask by `mode`:
  - 00 → lanes {0,1,2,3}.
  - 01 → lanes {0,2}.
  - 10 → lane {0}.
  - 11 → lane {0}.
- Strobes on disabled lanes are ignored silently. They do not count and do not set `overflow`.
- Accepted set A = `tree_stbs & mask`; N = popcount(A), 0..4.
- Push rule: if N ≤ free slots, where free = DEPTH − `level` evaluated at the start of the cycle, all N entries are written in ascending lane order in the same edge. Each entry is {lane, data}.
- Free-slot check ignores a pop occurring in the same cycle. This is conservative by design.
- Drop rule: if N > free, the whole group is dropped (no partial push), `overflow` is set to 1, and `res_count` is unchanged.
- Pop: `res_stb && res_ack` advances the read pointer by one.
- Push and pop in the same cycle are both performed; `level` = level + N − 1.
- Pointers are $clog2(DEPTH)+1 bits wide (wrap bit); full/empty are derived from pointer compare; wrap-around is seamless.
- `res_count` += N on every accepted push.
- `overflow` clears only on `rst`.
- Reset during any activity empties the FIFO next edge. In-flight strobes in the reset cycle are discarded.

## Timing
- Reset values:
  - `res_stb`=0, `res_data`=0, `res_lane`=0.
  - `res_count`=0, `overflow`=0, `level`=0.
  - Both pointers 0.
- Latency: strobe in cycle t → entry visible on `res_stb`/`res_data` in cycle t+1 (FIFO previously empty).
- `res_data`/`res_lane` are driven from registered FIFO storage at the read pointer and are stable while `res_stb`=1 and `res_ack`=0.
- `res_stb` is 1 exactly when `level` > 0.
- The consumer may hold `res_ack` high continuously: one result per cycle throughput.
- `res_ack` while `res_stb`=0 is ignored.
- `res_count`, `overflow` and `level` update on the same edge as the push/pop they reflect.
- `mode` change takes effect on strobes in the same cycle. Entries already queued are unaffected.

## Test plan
- Reset then idle → all outputs 0 for 5 cycles; `res_ack`=1 throughout causes no pointer movement.
- mode=00, one cycle `tree_stbs`=4'b1111, lanes = 0x3F80, 0x4000, 0x4040, 0x4080; `res_ack`=1 → cycles t+1..t+4 emit lanes 0,1,2,3 with those values, then `res_stb`=0; `res_count`=4.
- mode=01, `tree_stbs`=4'b1111 → only lanes 0,2 queued; `res_count`=2; `overflow`=0.
- DEPTH=16, `res_ack`=0, four cycles of 4'b1111 in mode 00 → `level`=16; a fifth group is dropped → `overflow`=1, `level`=16, `res_count`=16. Then drain 16 beats in order with `res_ack`=1.
- Level 14, `res_ack`=1, group of 3 in the same cycle → group dropped (free=2 < 3 despite the pop); `level`=13 next cycle.
- Queue 3 results, assert `rst` mid-drain → next cycle `res_stb`=0, `level`=0, `res_count`=0, `overflow`=0.
- `res_count` preloaded near wrap by pushing 65535 results → next 2 accepted give `res_count`=1.

Source files
------------

// File: rtl/mul_tree_result_collector.sv
// Result collector for mul_tree_bf16: captures mode-filtered lane strobes into
// a FIFO of {lane, data} entries and drains them one per beat over stb/ack.
module mul_tree_result_collector #(
   parameter int DW    = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               mode,
   input  logic [4*DW-1:0]          tree_outputs,
   input  logic [3:0]               tree_stbs,
   output logic [DW-1:0]            res_data,
   output logic [1:0]               res_lane,
   output logic                     res_stb,
   input  logic                     res_ack,
   output logic [15:0]              res_count,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = DW + 2;

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [15:0]   res_count_q, res_count_d;
   logic          overflow_q, overflow_d;

   logic [3:0]    lane_mask;
   logic [3:0]    accepted;
   logic [2:0]    n_acc;
   logic [PW-1:0] level_cur;
   logic [PW-1:0] free_cur;
   logic          push_ok;
   logic          pop;
   logic [AW-1:0] slot;

   always_comb begin
      case (mode)
         2'b00:   lane_mask = 4'b1111;
         2'b01:   lane_mask = 4'b0101;
         default: lane_mask = 4'b0001;
      endcase
      accepted = tree_stbs & lane_mask;
      n_acc    = 3'(accepted[0]) + 3'(accepted[1]) + 3'(accepted[2]) + 3'(accepted[3]);
   end

   // Free space ignores a same-cycle pop, so a group only lands if it fits now.
   assign level_cur = wr_ptr_q - rd_ptr_q;
   assign free_cur  = PW'(DEPTH) - level_cur;
   assign push_ok   = (PW'(n_acc) <= free_cur);
   assign res_stb   = (wr_ptr_q != rd_ptr_q);
   assign pop       = res_stb && res_ack;

   always_comb begin
      mem_d = mem_q;
      slot  = wr_ptr_q[AW-1:0];
      if (push_ok) begin
         for (int k = 0; k < 4; k++) begin
            if (accepted[k]) begin
               mem_d[slot] = {2'(k), tree_outputs[k*DW +: DW]};
               slot        = slot + AW'(1);
            end
         end
      end
      wr_ptr_d    = push_ok ? wr_ptr_q + PW'(n_acc) : wr_ptr_q;
      rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      res_count_d = push_ok ? res_count_q + 16'(n_acc) : res_count_q;
      overflow_d  = overflow_q | ~push_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         res_count_q <= '0;
         overflow_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         res_count_q <= res_count_d;
         overflow_q  <= overflow_d;
         mem_q       <= mem_d;
      end
   end

   assign res_data  = mem_q[rd_ptr_q[AW-1:0]][DW-1:0];
   assign res_lane  = mem_q[rd_ptr_q[AW-1:0]][EW-1:DW];
   assign res_count = res_count_q;
   assign overflow  = overflow_q;
   assign level     = level_cur;

endmodule

// File: tb/tb_mul_tree_result_collector.sv
// Scoreboard bench for mul_tree_result_collector: stimulus pushes expected
// {lane, data} entries into a queue, a negedge monitor pops and compares.
module tb_mul_tree_result_collector;

   localparam int DW    = 16;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    mode = 2'b00;
   logic [63:0]   tree_outputs = '0;
   logic [3:0]    tree_stbs = '0;
   logic [15:0]   res_data;
   logic [1:0]    res_lane;
   logic          res_stb;
   logic          res_ack = 1'b0;
   logic [15:0]   res_count;
   logic          overflow;
   logic [4:0]    level;

   typedef struct {
      int          lane;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          model_level = 0;
   logic [15:0] model_count = '0;
   bit          model_ov = 1'b0;
   int          cur_level = 0;
   logic [15:0] cur_count = '0;
   bit          cur_ov = 1'b0;
   bit          mon_en = 1'b0;
   bit          expect_zero_data = 1'b0;
   int          total = 0;
   int          bad = 0;

   mul_tree_result_collector #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .mode         (mode),
      .tree_outputs (tree_outputs),
      .tree_stbs    (tree_stbs),
      .res_data     (res_data),
      .res_lane     (res_lane),
      .res_stb      (res_stb),
      .res_ack      (res_ack),
      .res_count    (res_count),
      .overflow     (overflow),
      .level        (level)
   );

   always #5 clk = ~clk;

   function automatic bit laneEnabled(input logic [1:0] m, input int k);
      if (m == 2'b00) return 1'b1;
      if (m == 2'b01) return (k == 0) || (k == 2);
      return k == 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle and advances the reference model to the state after the next edge.
   task automatic applyStimulus(input logic [1:0] m, input logic [3:0] s,
                                input logic [63:0] d, input bit a, input bit r);
      exp_t lst[$];
      @(posedge clk);
      #1;
      cur_level = model_level;
      cur_count = model_count;
      cur_ov    = model_ov;
      mode         = m;
      tree_stbs    = s;
      tree_outputs = d;
      res_ack      = r ? 1'b0 : a;
      rst          = r;
      if (r) begin
         exp_q.delete();
         model_level = 0;
         model_count = '0;
         model_ov    = 1'b0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (s[k] && laneEnabled(m, k)) begin
               exp_t e;
               e.lane = k;
               e.data = d[k*16 +: 16];
               lst.push_back(e);
            end
         end
         if (model_level > 0 && a) model_level--;
         if (lst.size() <= DEPTH - cur_level) begin
            foreach (lst[i]) exp_q.push_back(lst[i]);
            model_level += lst.size();
            model_count += 16'(lst.size());
         end else begin
            model_ov = 1'b1;
         end
      end
   endtask

   task automatic checkOutput();
      check("res_stb", int'(res_stb), int'(cur_level > 0));
      check("level", int'(level), cur_level);
      check("res_count", int'(res_count), int'(cur_count));
      check("overflow", int'(overflow), int'(cur_ov));
      if (expect_zero_data) begin
         check("idle_res_data", int'(res_data), 0);
         check("idle_res_lane", int'(res_lane), 0);
      end
      if (res_stb && res_ack) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("res_lane", int'(res_lane), e.lane);
            check("res_data", int'(res_data), int'(e.data));
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) checkOutput();
   end

   initial begin
      logic [63:0] vals;
      vals = {16'h4080, 16'h4040, 16'h4000, 16'h3F80};

      applyStimulus(2'b00, 4'b0000, '0, 1'b0, 1'b1);
      mon_en = 1'b1;
      applyStimulus(2'b00, 4'b0000, '0, 1'b0, 1'b1);

      // Idle with ack held high: nothing may move.
      expect_zero_data = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus(2'b00, 4'b0000, 64'(i * 32'h1234_5678), 1'b1, 1'b0);
      applyStimulus(2'b00, 4'b0000, '0, 1'b1, 1'b0);
      expect_zero_data = 1'b0;

      // Full group in mode 00 drained at one per cycle.
      applyStimulus(2'b00, 4'b1111, vals, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(2'b00, 4'b0000, '0, 1'b1, 1'b0);

      // Mode 01 keeps lanes 0 and 2 only.
      applyStimulus(2'b00, 4'b0000, '0, 1'b0, 1'b1);
      applyStimulus(2'b01, 4'b1111, vals, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(2'b01, 4'b0000, '0, 1'b1, 1'b0);

      // Fill to DEPTH, drop a fifth group, then drain.
      applyStimulus(2'b00, 4'b0000, '0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) applyStimulus(2'b00, 4'b1111, {$urandom, $urandom}, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) applyStimulus(2'b00, 4'b0000, '0, 1'b1, 1'b0);

      // Level 14 plus a same-cycle pop still cannot take a group of 3.
      applyStimulus(2'b00, 4'b0000, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(2'b00, 4'b1111, {$urandom, $urandom}, 1'b0, 1'b0);
      applyStimulus(2'b00, 4'b0011, {$urandom, $urandom}, 1'b0, 1'b0);
      applyStimulus(2'b00, 4'b0111, {$urandom, $urandom}, 1'b1, 1'b0);
      applyStimulus(2'b00, 4'b0001, {$urandom, $urandom}, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) applyStimulus(2'b00, 4'b0000, '0, 1'b1, 1'b0);

      // Reset in the middle of a drain.
      applyStimulus(2'b00, 4'b0000, '0, 1'b0, 1'b1);
      applyStimulus(2'b00, 4'b0111, vals, 1'b0, 1'b0);
      applyStimulus(2'b00, 4'b0000, '0, 1'b1, 1'b0);
      applyStimulus(2'b00, 4'b1111, vals, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(2'b00, 4'b0000, '0, 1'b1, 1'b0);

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(2'($urandom), 4'($urandom), {$urandom, $urandom},
                       ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
      end
      for (int i = 0; i < 20; i++) applyStimulus(2'b00, 4'b0000, '0, 1'b1, 1'b0);

      // Walk res_count to 0xFFFF, then two more results wrap it to 1.
      applyStimulus(2'b00, 4'b0000, '0, 1'b0, 1'b1);
      for (int i = 0; i < 65535; i++) applyStimulus(2'b10, 4'b0001, {48'h0, 16'(i)}, 1'b1, 1'b0);
      applyStimulus(2'b11, 4'b1111, {$urandom, $urandom}, 1'b1, 1'b0);
      applyStimulus(2'b10, 4'b1011, {$urandom, $urandom}, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(2'b00, 4'b0000, '0, 1'b1, 1'b0);
      check("count_wrapped", int'(model_count), 1);

      @(posedge clk);
      #1;
      mon_en = 1'b0;
      if (exp_q.size() != 0) check("undrained_entries", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
